seq_match_ctrl: RTL and testbench

Parametrised token-sequence matching controller. It tracks progress through an NUM_PARTS-long sequence of tokens, one token per `read` strobe, and restarts with overlap when a mismatching token matches part 1. It reports a match via `find` in sticky or pulse mode and keeps a saturating count of completed matches. It sits between the token comparator datapath, which supplies `valid`/`first_hit`, and the status/display logic.

---
 rtl/seq_match_pkg.sv | 7 +
 rtl/seq_match_ctrl_sat_counter.sv | 14 +
 rtl/seq_match_ctrl.sv | 71 +++++++
 tb/tb_seq_match_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/seq_match_pkg.sv
// seq_match_pkg: shared state encoding and width helper for the sequence matcher
package seq_match_pkg;
    typedef enum logic [1:0] {MATCH, FOUND, HALT} state_e;
    function automatic int part_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/seq_match_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones
// ports: clock, reset (sync, active-high), inc (count enable), q (count value)
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clock)
        if (reset) q <= '0;
        else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/seq_match_ctrl.sv
// seq_match_ctrl: tracks progress through a NUM_PARTS-token sequence and flags/counts matches
// ports: clock, reset (sync, active-high); read/valid/first_hit token strobe and compare results;
//        stop (abort to HALT), clear (soft restart); which_part (expected part, 0 outside MATCH),
//        find (match found), halted (stopped), match_count (saturating completed matches)
module seq_match_ctrl
    import seq_match_pkg::*;
#(
    parameter  int NUM_PARTS = 4,
    parameter  int STICKY    = 1,
    parameter  int CNT_W     = 8,
    localparam int PART_W    = part_w(NUM_PARTS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              read,
    input  logic              valid,
    input  logic              first_hit,
    input  logic              stop,
    input  logic              clear,
    output logic [PART_W-1:0] which_part,
    output logic              find,
    output logic              halted,
    output logic [CNT_W-1:0]  match_count
);
    localparam logic [PART_W-1:0] ONE  = PART_W'(1);
    localparam logic [PART_W-1:0] TWO  = PART_W'(2);
    localparam logic [PART_W-1:0] LAST = PART_W'(NUM_PARTS);
    state_e            state_q, state_d;
    logic [PART_W-1:0] part_q, part_d;
    logic              inc;
    always_ff @(posedge clock)
        if (reset) begin
            state_q <= MATCH;
            part_q  <= ONE;
        end else begin
            state_q <= state_d;
            part_q  <= part_d;
        end
    always_comb begin
        state_d = state_q;
        part_d  = part_q;
        inc     = 1'b0;
        if (stop) begin
            state_d = HALT;
            part_d  = ONE;
        end else if (clear) begin
            state_d = MATCH;
            part_d  = ONE;
        end else if (state_q == MATCH && read) begin
            if (valid && part_q == LAST) begin
                state_d = FOUND;
                part_d  = ONE;
                inc     = 1'b1;
            end else
                part_d = valid ? part_q + ONE : (first_hit ? TWO : ONE);
        end else if (state_q == FOUND && STICKY == 0) begin
            // pulse mode: the FOUND cycle's read is judged against part 1
            state_d = MATCH;
            part_d  = (read && valid) ? TWO : ONE;
        end
    end
    assign which_part = (state_q == MATCH) ? part_q : '0;
    assign find       = (state_q == FOUND);
    assign halted     = (state_q == HALT);
    sat_counter #(.W(CNT_W)) u_cnt (
        .clock(clock),
        .reset(reset),
        .inc  (inc),
        .q    (match_count)
    );
endmodule

// File: tb/tb_seq_match_ctrl.sv
// tb_seq_match_ctrl: directed checks on three configurations of the sequence matcher
module tb_seq_match_ctrl;
    logic       clock = 0, reset = 1;
    logic [2:0] read = 0, valid = 0, first_hit = 0, stop = 0, clear = 0;
    logic [2:0] wp0;
    logic [1:0] wp1, wp2;
    logic [2:0] find, halted;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;
    int errors = 0, checks = 0;

    always #5 clock = ~clock;

    seq_match_ctrl #(.NUM_PARTS(4), .STICKY(1), .CNT_W(8)) d0 (
        .clock(clock), .reset(reset), .read(read[0]), .valid(valid[0]), .first_hit(first_hit[0]),
        .stop(stop[0]), .clear(clear[0]), .which_part(wp0), .find(find[0]), .halted(halted[0]),
        .match_count(cnt0));
    seq_match_ctrl #(.NUM_PARTS(3), .STICKY(0), .CNT_W(8)) d1 (
        .clock(clock), .reset(reset), .read(read[1]), .valid(valid[1]), .first_hit(first_hit[1]),
        .stop(stop[1]), .clear(clear[1]), .which_part(wp1), .find(find[1]), .halted(halted[1]),
        .match_count(cnt1));
    seq_match_ctrl #(.NUM_PARTS(2), .STICKY(0), .CNT_W(2)) d2 (
        .clock(clock), .reset(reset), .read(read[2]), .valid(valid[2]), .first_hit(first_hit[2]),
        .stop(stop[2]), .clear(clear[2]), .which_part(wp2), .find(find[2]), .halted(halted[2]),
        .match_count(cnt2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int d, input logic r, input logic v, input logic f,
                        input logic s, input logic c);
        read[d] = r; valid[d] = v; first_hit[d] = f; stop[d] = s; clear[d] = c;
        @(posedge clock);
        #1;
        read[d] = 0; valid[d] = 0; first_hit[d] = 0; stop[d] = 0; clear[d] = 0;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1 reset = 0;
        chk("rst_wp0", 32'(wp0), 1);
        chk("rst_wp1", 32'(wp1), 1);
        chk("rst_wp2", 32'(wp2), 1);
        chk("rst_find", 32'(find), 0);
        chk("rst_halt", 32'(halted), 0);
        chk("rst_cnt0", 32'(cnt0), 0);

        // sticky NUM_PARTS=4: four valid reads
        step(0, 1, 1, 0, 0, 0); chk("s_wp_a", 32'(wp0), 2);
        step(0, 1, 1, 0, 0, 0); chk("s_wp_b", 32'(wp0), 3);
        step(0, 1, 1, 0, 0, 0); chk("s_wp_c", 32'(wp0), 4);
        chk("s_find_early", 32'(find[0]), 0);
        step(0, 1, 1, 0, 0, 0); chk("s_wp_d", 32'(wp0), 0);
        chk("s_find", 32'(find[0]), 1);
        chk("s_cnt", 32'(cnt0), 1);
        step(0, 1, 1, 0, 0, 0); chk("s_hold_find", 32'(find[0]), 1);
        chk("s_hold_cnt", 32'(cnt0), 1);
        chk("s_hold_wp", 32'(wp0), 0);
        step(0, 0, 0, 0, 0, 1); chk("s_clr_wp", 32'(wp0), 1);
        chk("s_clr_find", 32'(find[0]), 0);
        chk("s_clr_cnt", 32'(cnt0), 1);

        // overlap restart
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0); chk("ov_p3", 32'(wp0), 3);
        step(0, 1, 0, 1, 0, 0); chk("ov_fh", 32'(wp0), 2);
        step(0, 1, 0, 0, 0, 0); chk("ov_miss", 32'(wp0), 1);
        step(0, 1, 1, 1, 0, 0); chk("ov_valid_prio", 32'(wp0), 2);
        step(0, 0, 1, 1, 0, 0); chk("ov_noread", 32'(wp0), 2);

        // stop with final valid read
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0); chk("st_p4", 32'(wp0), 4);
        step(0, 1, 1, 0, 1, 0); chk("st_halt", 32'(halted[0]), 1);
        chk("st_find", 32'(find[0]), 0);
        chk("st_cnt", 32'(cnt0), 1);
        chk("st_wp", 32'(wp0), 0);
        step(0, 1, 1, 0, 0, 0); chk("st_stay", 32'(halted[0]), 1);
        step(0, 0, 0, 0, 1, 1); chk("st_prio", 32'(halted[0]), 1);
        step(0, 0, 0, 0, 0, 1); chk("st_clr_halt", 32'(halted[0]), 0);
        chk("st_clr_wp", 32'(wp0), 1);

        // pulse mode NUM_PARTS=3: nine valid reads
        for (int i = 1; i <= 9; i++) begin
            step(1, 1, 1, 0, 0, 0);
            chk($sformatf("p_find%0d", i), 32'(find[1]), (i % 3 == 0) ? 1 : 0);
            chk($sformatf("p_wp%0d", i), 32'(wp1), (i % 3 == 0) ? 0 : ((i % 3 == 1) ? 2 : 3));
        end
        chk("p_cnt", 32'(cnt1), 3);
        step(1, 0, 0, 0, 0, 0); chk("p_idle_find", 32'(find[1]), 0);
        chk("p_idle_wp", 32'(wp1), 1);
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0); chk("p_find4", 32'(find[1]), 1);
        step(1, 1, 0, 1, 0, 0); chk("p_found_miss", 32'(wp1), 1);
        chk("p_cnt4", 32'(cnt1), 4);

        // CNT_W=2, NUM_PARTS=2: five matches saturate
        for (int i = 1; i <= 10; i++) begin
            step(2, 1, 1, 0, 0, 0);
            if (i % 2 == 0) chk($sformatf("sat_cnt%0d", i), 32'(cnt2), (i / 2 > 3) ? 3 : i / 2);
            else chk($sformatf("sat_wp%0d", i), 32'(wp2), 2);
        end
        chk("sat_find", 32'(find[2]), 1);

        // reset mid-sequence with read active
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0); chk("r_p3", 32'(wp0), 3);
        read[0] = 1; valid[0] = 1; reset = 1;
        @(posedge clock);
        #1 read[0] = 0; valid[0] = 0; reset = 0;
        chk("r_wp", 32'(wp0), 1);
        chk("r_find", 32'(find[0]), 0);
        chk("r_cnt0", 32'(cnt0), 0);
        chk("r_cnt2", 32'(cnt2), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
